// File: rtl/ro_count_ctrl.sv
// rtl/ro_count_ctrl.sv - ring-oscillator edge-count measurement controller
module ro_count_ctrl #(
    parameter int WIN_W  = 10,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Start,
    input  logic [WIN_W-1:0] i_Win_Len,
    input  logic             i_RO_Clk,
    output logic             o_RO_Enable,
    output logic             o_RO_Sel,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [CNT_W-1:0] o_Count,
    output logic             o_Ovf
);

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [SET_W-1:0] SET_ONE  = 1;
    localparam logic [WIN_W-1:0] WIN_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [WIN_W-1:0] win_len_q, win_len_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic             drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] work_cnt_q, work_cnt_d;
    logic             work_ovf_q, work_ovf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             hist_q, hist_d;
    logic             ro_edge;

    // The history flop tracks sync2 every cycle, so on COUNT entry it already
    // holds the current synchronized level and no spurious edge is seen.
    assign ro_edge = sync2_q & ~hist_q;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        win_len_d    = win_len_q;
        win_cnt_d    = win_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        work_cnt_d   = work_cnt_q;
        work_ovf_d   = work_ovf_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        sync1_d      = i_RO_Clk;
        sync2_d      = sync1_q;
        hist_d       = sync2_q;

        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    win_len_d    = i_Win_Len;
                    settle_cnt_d = '0;
                    work_cnt_d   = '0;
                    work_ovf_d   = 1'b0;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SET_LAST) begin
                    if (win_len_q != '0) begin
                        win_cnt_d  = '0;
                        work_cnt_d = '0;
                        work_ovf_d = 1'b0;
                        state_d    = ST_COUNT;
                    end else begin
                        drain_cnt_d = 1'b0;
                        state_d     = ST_DRAIN;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_ONE;
                end
            end
            ST_COUNT: begin
                if (ro_edge) begin
                    if (work_cnt_q == CNT_MAX) begin
                        work_ovf_d = 1'b1;
                    end else begin
                        work_cnt_d = work_cnt_q + CNT_ONE;
                    end
                end
                if (win_cnt_q == win_len_q - WIN_ONE) begin
                    drain_cnt_d = 1'b0;
                    state_d     = ST_DRAIN;
                end else begin
                    win_cnt_d = win_cnt_q + WIN_ONE;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        en_d   = (state_d == ST_SETTLE) || (state_d == ST_COUNT);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_DONE) begin
            count_d = work_cnt_q;
            ovf_d   = work_ovf_q;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            win_len_q    <= '0;
            win_cnt_q    <= '0;
            drain_cnt_q  <= 1'b0;
            work_cnt_q   <= '0;
            work_ovf_q   <= 1'b0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            hist_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            win_len_q    <= win_len_d;
            win_cnt_q    <= win_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            work_cnt_q   <= work_cnt_d;
            work_ovf_q   <= work_ovf_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            hist_q       <= hist_d;
        end
    end

    assign o_RO_Enable = en_q;
    assign o_RO_Sel    = en_q;
    assign o_Busy      = busy_q;
    assign o_Done      = done_q;
    assign o_Count     = count_q;
    assign o_Ovf       = ovf_q;

endmodule

// File: tb/tb_ro_count_ctrl.sv
// tb/tb_ro_count_ctrl.sv - directed vector bench for ro_count_ctrl
module tb_ro_count_ctrl;

    localparam int WIN_W  = 10;
    localparam int CNT_W  = 4;
    localparam int SETTLE = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIN_W-1:0] win = '0;
    logic             ro = 1'b0;
    logic             o_RO_Enable, o_RO_Sel, o_Busy, o_Done, o_Ovf;
    logic [CNT_W-1:0] o_Count;

    int n_vec = 0;
    int n_err = 0;

    ro_count_ctrl #(.WIN_W(WIN_W), .CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Start    (start),
        .i_Win_Len  (win),
        .i_RO_Clk   (ro),
        .o_RO_Enable(o_RO_Enable),
        .o_RO_Sel   (o_RO_Sel),
        .o_Busy     (o_Busy),
        .o_Done     (o_Done),
        .o_Count    (o_Count),
        .o_Ovf      (o_Ovf)
    );

    always #5 clk = ~clk;

    // RO period is 8 reference cycles, phase-offset from the clock edges.
    initial begin
        #3;
        forever #40 ro = ~ro;
    end

    typedef struct {
        int win;
        int cnt_lo;
        int cnt_hi;
        int ovf;
        bit poke;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic run_meas(input int n, input bit poke, output int done_t, output int done_n,
                            output int en_last, output int busy_last, output int sel_bad);
        int limit;
        limit = SETTLE + n + 8;
        @(negedge clk);
        start = 1'b1;
        win   = WIN_W'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        win   = ~WIN_W'(n);
        done_t = -1; done_n = 0; en_last = -1; busy_last = -1; sel_bad = 0;
        for (int t = 0; t <= limit; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (o_RO_Enable) en_last = t;
            if (o_Busy) busy_last = t;
            if (o_RO_Sel != o_RO_Enable) sel_bad++;
            if (o_Done) begin
                done_n++;
                if (done_t < 0) done_t = t;
            end
            start = poke && (t == SETTLE + 2 || t == SETTLE + n);
        end
        start = 1'b0;
    endtask

    task automatic check_meas(input int n, input bit poke, input int lo, input int hi, input int ovf);
        int dt, dn, el, bl, sb;
        run_meas(n, poke, dt, dn, el, bl, sb);
        chk("done_time", dt, SETTLE + n + 2);
        chk("done_pulses", dn, 1);
        chk("enable_last", el, SETTLE + n - 1);
        chk("busy_last", bl, SETTLE + n + 2);
        chk("sel_tracks_en", sb, 0);
        chk_rng("count", int'(o_Count), lo, hi);
        chk("ovf", int'(o_Ovf), ovf);
    endtask

    initial begin
        int seen;
        vecs[0] = '{win: 64,  cnt_lo: 7,  cnt_hi: 9,  ovf: 0, poke: 1'b0};
        vecs[1] = '{win: 0,   cnt_lo: 0,  cnt_hi: 0,  ovf: 0, poke: 1'b0};
        vecs[2] = '{win: 320, cnt_lo: 15, cnt_hi: 15, ovf: 1, poke: 1'b0};
        vecs[3] = '{win: 16,  cnt_lo: 1,  cnt_hi: 3,  ovf: 0, poke: 1'b0};
        vecs[4] = '{win: 32,  cnt_lo: 3,  cnt_hi: 5,  ovf: 0, poke: 1'b1};

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_enable", int'(o_RO_Enable), 0);
        chk("rst_sel", int'(o_RO_Sel), 0);
        chk("rst_busy", int'(o_Busy), 0);
        chk("rst_done", int'(o_Done), 0);
        chk("rst_count", int'(o_Count), 0);
        chk("rst_ovf", int'(o_Ovf), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            check_meas(vecs[i].win, vecs[i].poke, vecs[i].cnt_lo, vecs[i].cnt_hi, vecs[i].ovf);
        end

        // Held start: second run accepted the cycle after returning to IDLE
        @(negedge clk);
        start = 1'b1;
        win   = WIN_W'(8);
        @(posedge clk);
        #1;
        for (int t = 1; t <= SETTLE + 8 + 4; t++) begin
            @(posedge clk);
            #1;
            if (t == SETTLE + 8 + 2) chk("held_done", int'(o_Done), 1);
            if (t == SETTLE + 8 + 3) chk("held_busy_gap", int'(o_Busy), 0);
            if (t == SETTLE + 8 + 4) chk("held_restart", int'(o_Busy), 1);
        end
        start = 1'b0;
        seen = 0;
        for (int t = 0; t < 40 && seen == 0; t++) begin
            @(posedge clk);
            #1;
            if (o_Done) seen = 1;
        end
        chk("held_second_done", seen, 1);
        repeat (3) @(posedge clk);

        // Abort in COUNT
        @(negedge clk);
        start = 1'b1;
        win   = WIN_W'(64);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int t = 1; t <= SETTLE + 10; t++) begin
            @(posedge clk);
            #1;
        end
        chk("abort_pre_busy", int'(o_Busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_enable", int'(o_RO_Enable), 0);
        chk("abort_busy", int'(o_Busy), 0);
        chk("abort_done", int'(o_Done), 0);
        chk("abort_count", int'(o_Count), 0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        for (int t = 0; t < 80; t++) begin
            @(posedge clk);
            #1;
            if (o_Done || o_Busy) seen++;
        end
        chk("abort_quiet", seen, 0);

        check_meas(64, 1'b0, 7, 9, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
